writeback_arbiter: RTL and testbench

//  Parametrised writeback stage. Merges results from NUM_SRC producers (ALU, LSU, MUL/DIV, ...)

---
 rtl/writeback_arbiter.sv | 111 +++++++++++
 tb/tb_writeback_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-source result FIFOs merged round-robin onto one register-file write port
module writeback_arbiter #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    output logic                      reg_wr_en,
    output logic [ADDR_W-1:0]         reg_wr_addr,
    output logic [XLEN-1:0]           reg_wr_data,
    output logic                      busy
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + XLEN;

    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [ENT_W-1:0]   w_head [NUM_SRC];
    logic               w_grant_vld;
    logic [IDX_W-1:0]   w_grant;

    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [XLEN-1:0]    r_wr_data;
    logic [IDX_W-1:0]   r_rr_ptr;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= NUM_SRC) ? IDX_W'(v - NUM_SRC) : IDX_W'(v);
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ENT_W-1:0] r_mem [DEPTH];
        logic [PW:0]      r_wptr;
        logic [PW:0]      r_rptr;

        // Pointers carry one extra wrap bit so equal indices mean full when the wrap bits differ
        assign w_empty[g] = (r_wptr == r_rptr);
        assign w_full[g]  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
        assign w_head[g]  = r_mem[r_rptr[PW-1:0]];

        // Results for x0 are acknowledged but never enter the queue
        assign w_push[g] = src_valid[g] && !w_full[g] && !flush &&
                           (src_addr[g*ADDR_W +: ADDR_W] != '0);
        assign w_pop[g]  = w_grant_vld && (w_grant == IDX_W'(g)) && !flush;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push[g]) r_wptr <= r_wptr + 1'b1;
                if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[g]) begin
                r_mem[r_wptr[PW-1:0]] <= {src_addr[g*ADDR_W +: ADDR_W], src_data[g*XLEN +: XLEN]};
            end
        end
    end

    // Scan from the highest offset down so the source nearest rr_ptr is the last to win
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (!w_empty[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_grant_vld = 1'b1;
                w_grant     = wrap_idx(int'(r_rr_ptr) + k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rr_ptr  <= '0;
        end else if (flush) begin
            r_wr_en  <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_wr_en                <= 1'b1;
            {r_wr_addr, r_wr_data} <= w_head[w_grant];
            r_rr_ptr               <= wrap_idx(int'(w_grant) + 1);
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign src_ready   = ~w_full;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign busy        = (|(~w_empty)) | r_wr_en;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - vector table, corner sequences and randomized run against a queue model
module tb_writeback_arbiter;
    localparam int NS = 2;
    localparam int DP = 2;
    localparam int AW = 5;
    localparam int XW = 32;

    typedef logic [AW+XW-1:0] ent_t;

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        fl;
        logic [1:0]  rdy;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS-1:0]    src_ready;
    logic [NS*AW-1:0] src_addr = '0;
    logic [NS*XW-1:0] src_data = '0;
    logic             reg_wr_en;
    logic [AW-1:0]    reg_wr_addr;
    logic [XW-1:0]    reg_wr_data;
    logic             busy;

    int total = 0;
    int bad = 0;

    ent_t          m_q [NS][DP];
    int            m_cnt [NS];
    int            m_rr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [XW-1:0] m_data;

    vec_t tbl [20];

    writeback_arbiter #(.XLEN(XW), .ADDR_W(AW), .NUM_SRC(NS), .DEPTH(DP)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
        m_rr = 0;
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic [NS-1:0] exp_ready();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (m_cnt[i] < DP);
        return r;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = m_en;
        for (int i = 0; i < NS; i++) if (m_cnt[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_edge(input logic [NS-1:0] v, input logic [NS*AW-1:0] a,
                              input logic [NS*XW-1:0] d, input logic fl);
        logic [NS-1:0] rdy;
        int win;
        rdy = exp_ready();
        if (fl) begin
            for (int i = 0; i < NS; i++) m_cnt[i] = 0;
            m_en = 1'b0;
            m_rr = 0;
            return;
        end
        win = -1;
        for (int k = 0; k < NS; k++) begin
            int i;
            i = (m_rr + k) % NS;
            if (win < 0 && m_cnt[i] > 0) win = i;
        end
        if (win >= 0) begin
            {m_addr, m_data} = m_q[win][0];
            for (int j = 0; j < DP - 1; j++) m_q[win][j] = m_q[win][j+1];
            m_cnt[win]--;
            m_en = 1'b1;
            m_rr = (win + 1) % NS;
        end else begin
            m_en = 1'b0;
        end
        for (int i = 0; i < NS; i++) begin
            if (v[i] && rdy[i] && a[i*AW +: AW] != '0) begin
                m_q[i][m_cnt[i]] = {a[i*AW +: AW], d[i*XW +: XW]};
                m_cnt[i]++;
            end
        end
    endtask

    task automatic cycle(input logic [NS-1:0] v, input logic [NS*AW-1:0] a,
                         input logic [NS*XW-1:0] d, input logic fl, output logic [NS-1:0] rdy_seen);
        src_valid = v;
        src_addr = a;
        src_data = d;
        flush = fl;
        #1;
        rdy_seen = src_ready;
        chk("src_ready", 64'(src_ready), 64'(exp_ready()));
        chk("busy", 64'(busy), 64'(exp_busy()));
        model_edge(v, a, d, fl);
        @(posedge clk);
        #1;
        chk("wr_en", 64'(reg_wr_en), 64'(m_en));
        chk("wr_addr", 64'(reg_wr_addr), 64'(m_addr));
        chk("wr_data", 64'(reg_wr_data), 64'(m_data));
    endtask

    initial begin
        logic [NS-1:0]    rs;
        logic [NS*AW-1:0] ra;
        logic [NS*XW-1:0] rd;

        tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[3]  = '{2'b01, 5'd0, 32'h1,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[4]  = '{2'b01, 5'd7, 32'h2,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b1, 5'd7, 32'h2};
        tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd7, 32'h2};
        tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b1, 2'b11, 1'b0, 5'd7, 32'h2};
        tbl[8]  = '{2'b11, 5'd1, 32'hA0,       5'd2, 32'hB0,  1'b0, 2'b11, 1'b0, 5'd7, 32'h2};
        tbl[9]  = '{2'b11, 5'd1, 32'hA1,       5'd2, 32'hB1,  1'b0, 2'b11, 1'b1, 5'd1, 32'hA0};
        tbl[10] = '{2'b11, 5'd1, 32'hA2,       5'd2, 32'hB2,  1'b0, 2'b01, 1'b1, 5'd2, 32'hB0};
        tbl[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b10, 1'b1, 5'd1, 32'hA1};
        tbl[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b1, 5'd2, 32'hB1};
        tbl[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b1, 5'd1, 32'hA2};
        tbl[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd1, 32'hA2};
        tbl[15] = '{2'b11, 5'd3, 32'hC0,       5'd4, 32'hD0,  1'b0, 2'b11, 1'b0, 5'd1, 32'hA2};
        tbl[16] = '{2'b11, 5'd3, 32'hC1,       5'd4, 32'hD1,  1'b0, 2'b11, 1'b1, 5'd4, 32'hD0};
        tbl[17] = '{2'b11, 5'd3, 32'hC2,       5'd4, 32'hD2,  1'b0, 2'b10, 1'b1, 5'd3, 32'hC0};
        tbl[18] = '{2'b11, 5'd3, 32'hC3,       5'd4, 32'hD3,  1'b1, 2'b01, 1'b0, 5'd3, 32'hC0};
        tbl[19] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   1'b0, 2'b11, 1'b0, 5'd3, 32'hC0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(src_ready), 64'(2'b11));
        chk("rst_wr_en", 64'(reg_wr_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset_n = 1'b1;

        for (int n = 0; n < 10; n++) cycle('0, '0, '0, 1'b0, rs);

        for (int n = 0; n < 20; n++) begin
            cycle(tbl[n].v, {tbl[n].a1, tbl[n].a0}, {tbl[n].d1, tbl[n].d0}, tbl[n].fl, rs);
            chk($sformatf("vec%0d_ready", n), 64'(rs), 64'(tbl[n].rdy));
            chk($sformatf("vec%0d_en", n), 64'(reg_wr_en), 64'(tbl[n].en));
            chk($sformatf("vec%0d_addr", n), 64'(reg_wr_addr), 64'(tbl[n].addr));
            chk($sformatf("vec%0d_data", n), 64'(reg_wr_data), 64'(tbl[n].data));
        end

        cycle(2'b11, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b0, rs);
        cycle(2'b11, {5'd9, 5'd8}, {32'h9A, 32'h8A}, 1'b0, rs);
        chk("pre_rst_en", 64'(reg_wr_en), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(reg_wr_en), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ready", 64'(src_ready), 64'(2'b11));
        chk("mid_rst_addr", 64'(reg_wr_addr), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) cycle('0, '0, '0, 1'b0, rs);

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NS; i++) begin
                ra[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
                rd[i*XW +: XW] = $urandom;
            end
            cycle(NS'($urandom), ra, rd, ($urandom_range(0, 31) == 0), rs);
        end
        for (int n = 0; n < 6; n++) cycle('0, '0, '0, 1'b0, rs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
